// File: rtl/alu_pipe.sv
// alu_pipe: two-stage Y86 OPq ALU with valid/ready handshake
// and an architectural condition-code register.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [2:0]       cc
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid_q;
  logic [1:0]       s1_ifun_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_scc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;
  logic             s2_scc_q;
  logic [2:0]       cc_q;

  logic             retire;
  logic             s1_adv;
  logic             accept;

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res_d;
  logic             of_d;

  assign retire   = s2_valid_q && out_ready;
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  // Sub reuses the adder: a + ~b + 1
  assign is_sub   = (s1_ifun_q == 2'd1);
  assign is_arith = !s1_ifun_q[1];
  assign bx       = is_sub ? ~s1_b_q : s1_b_q;
  assign sum      = s1_a_q + bx
                  + {{(WIDTH-1){1'b0}}, is_sub};

  always_comb begin
    res_d = '0;
    unique case (s1_ifun_q)
      2'd0:    res_d = sum;
      2'd1:    res_d = sum;
      2'd2:    res_d = s1_a_q & s1_b_q;
      2'd3:    res_d = s1_a_q ^ s1_b_q;
      default: res_d = '0;
    endcase
  end

  // Operand signs as seen by the adder cover both add and sub
  assign of_d = is_arith
             && (s1_a_q[MSB] == bx[MSB])
             && (sum[MSB] != s1_a_q[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ifun_q  <= 2'd0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_scc_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_ifun_q  <= ifun;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_scc_q   <= set_cc;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zf_q       <= 1'b1;
      sf_q       <= 1'b0;
      of_q       <= 1'b0;
      s2_scc_q   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      res_q      <= res_d;
      zf_q       <= (res_d == '0);
      sf_q       <= res_d[MSB];
      of_q       <= of_d;
      s2_scc_q   <= s1_scc_q;
    end else if (retire) begin
      s2_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= 3'b100;
    end else if (retire && s2_scc_q) begin
      cc_q <= {zf_q, sf_q, of_q};
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand-built sequences
// for backpressure, mid-flight reset and an 8-bit instance.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  ifun;
  logic [63:0] a, b;
  logic        set_cc;
  logic        out_valid, out_ready;
  logic [63:0] result;
  logic        zf, sf, of;
  logic [2:0]  cc;

  logic        v8, ir8, sc8, ov8, or8;
  logic [1:0]  f8;
  logic [7:0]  a8, b8, r8;
  logic        z8, s8, o8;
  logic [2:0]  cc8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ifun(ifun), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .sf(sf), .of(of),
    .cc(cc)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(ir8),
    .ifun(f8), .a(a8), .b(b8), .set_cc(sc8),
    .out_valid(ov8), .out_ready(or8),
    .result(r8), .zf(z8), .sf(s8), .of(o8),
    .cc(cc8)
  );

  typedef struct {
    logic [1:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic        scc;
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        of;
  } vec_t;

  localparam int N = 11;
  vec_t vec [N];

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ABCD = 64'hABCD_ABCD_ABCD_ABCD;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] f,
                       input logic [63:0] x,
                       input logic [63:0] y,
                       input logic s);
    in_valid = v; ifun = f; a = x; b = y; set_cc = s;
  endtask

  logic [2:0] cc_exp;

  initial begin
    vec[0]  = '{2'd1, -64'd456, -64'd154, 1'b1,
                -64'd302, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{2'd1, 64'd25620, -64'd5264, 1'b0,
                64'd30884, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{2'd1, 64'd58974, -64'd254781, 1'b0,
                64'd313755, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{2'd1, 64'd45871, 64'd154, 1'b1,
                64'd45717, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{2'd1, ABCD, ABCD, 1'b1,
                64'd0, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{2'd0, MAXP, 64'd1, 1'b1,
                MINN, 1'b0, 1'b1, 1'b1};
    vec[6]  = '{2'd1, MINN, 64'd1, 1'b0,
                MAXP, 1'b0, 1'b0, 1'b1};
    vec[7]  = '{2'd2, MAXP, 64'd1, 1'b0,
                64'd1, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{2'd3, MAXP, 64'd1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{2'd2, MINN, 64'd1, 1'b0,
                64'd0, 1'b1, 1'b0, 1'b0};
    vec[10] = '{2'd3, MINN, 64'd1, 1'b1,
                64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    v8 = 1'b0; f8 = 2'd0; a8 = 8'd0; b8 = 8'd0;
    sc8 = 1'b0; or8 = 1'b1;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zf", 64'(zf), 64'd1);
    chk("rst_sf", 64'(sf), 64'd0);
    chk("rst_of", 64'(of), 64'd0);
    chk("rst_cc", 64'(cc), 64'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    cc_exp = 3'b100;

    // back-to-back stream, 2-cycle latency
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("vec_valid", 64'(out_valid), 64'd1);
        chk("vec_res", result, vec[i-2].res);
        chk("vec_zf", 64'(zf), 64'(vec[i-2].zf));
        chk("vec_sf", 64'(sf), 64'(vec[i-2].sf));
        chk("vec_of", 64'(of), 64'(vec[i-2].of));
        chk("vec_cc", 64'(cc), 64'(cc_exp));
        if (vec[i-2].scc)
          cc_exp = {vec[i-2].zf, vec[i-2].sf, vec[i-2].of};
      end
      chk("vec_in_ready", 64'(in_ready), 64'd1);
      if (i < N)
        drive(1'b1, vec[i].ifun, vec[i].a, vec[i].b,
              vec[i].scc);
      else
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    end
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_cc", 64'(cc), 64'(cc_exp));

    // backpressure: A accepted, B accepted, C blocked
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 64'd1, 64'd2, 1'b0);
    @(negedge clk);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    drive(1'b1, 2'd1, 64'd3, 64'd3, 1'b1);
    @(negedge clk);
    chk("bp_full", 64'(in_ready), 64'd0);
    drive(1'b1, 2'd3, 64'hF0, 64'hFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready0", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_res", result, 64'd3);
      chk("bp_hold_cc", 64'(cc), 64'(cc_exp));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    chk("bp_res_b", result, 64'd0);
    chk("bp_zf_b", 64'(zf), 64'd1);
    @(negedge clk);
    chk("bp_res_c", result, 64'h0F);
    chk("bp_valid_c", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_cc", 64'(cc), 64'd4);

    // mid-flight reset: first make cc differ from its reset value
    drive(1'b1, 2'd0, MAXP, 64'd1, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_cc_pre", 64'(cc), 64'd3);
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 64'd1, 64'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd1, 64'd0, 64'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    chk("mr_full", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 64'(out_valid), 64'd0);
    chk("mr_async_cc", 64'(cc), 64'd4);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_res", result, 64'd0);
    chk("mr_zf", 64'(zf), 64'd1);
    @(negedge clk);
    chk("mr_no_ghost", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 2'd0, 64'd2, 64'd3, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    chk("mr_next_valid", 64'(out_valid), 64'd1);
    chk("mr_next_res", result, 64'd5);
    chk("mr_next_cc_pre", 64'(cc), 64'd4);
    @(negedge clk);
    chk("mr_next_cc", 64'(cc), 64'd0);
    chk("mr_next_empty", 64'(out_valid), 64'd0);

    // 8-bit instance
    v8 = 1'b1; f8 = 2'd0; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    f8 = 2'd1; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    v8 = 1'b0;
    chk("w8_valid", 64'(ov8), 64'd1);
    chk("w8_add_res", 64'(r8), 64'h80);
    chk("w8_add_sf", 64'(s8), 64'd1);
    chk("w8_add_of", 64'(o8), 64'd1);
    @(negedge clk);
    chk("w8_sub_res", 64'(r8), 64'hFF);
    chk("w8_sub_sf", 64'(s8), 64'd1);
    chk("w8_sub_of", 64'(o8), 64'd0);
    chk("w8_sub_zf", 64'(z8), 64'd0);
    @(negedge clk);
    chk("w8_empty", 64'(ov8), 64'd0);
    chk("w8_cc", 64'(cc8), 64'd4);
    chk("w8_ready", 64'(ir8), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined integer ALU for the Y86 execute stage. It generalises the fixed 64-bit subtractor to a configurable width and the four Y86 OPq functions (add, sub, and, xor), and produces per-result ZF/SF/OF flags. It adds a valid/ready handshake with backpressure and an architectural condition-code register, updated only for results tagged `set_cc`.

## Interface
- `WIDTH`, default 64: operand/result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  ALU can accept; transfer when `in_valid && in_ready`.
- `ifun`  in  2  function: 0 = add (a+b), 1 = sub (a−b), 2 = and, 3 = xor.
- `a`, `b`  in  WIDTH  two's-complement operands.
- `set_cc`  in  1  this operation updates `cc` when it retires.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts; retire when `out_valid && out_ready`.
- `result`  out  WIDTH  operation result, modulo 2^WIDTH.
- `zf`, `sf`, `of`  out  1 each  flags of the current `result`.
- `cc`  out  3  architectural condition codes {ZF,SF,OF}.

## Operation
- Stage 1 (S1) registers `ifun`, `a`, `b`, `set_cc` on input transfer. Stage 2 (S2) registers the computed `result`, flags and `set_cc` tag.
- Arithmetic is WIDTH-bit wraparound. Sub is a + ~b + 1, with no separate subtractor.
- ZF = (result == 0). SF = result[WIDTH−1].
- OF for add: a, b same sign and result sign ≠ a sign. OF for sub: a, b differ in sign and result sign ≠ a sign. OF for and/xor: 0.
- The S2 `set_cc` tag is not output. It is used only for the `cc` update.
- `cc` loads {zf,sf,of} on a retire whose tag is 1. Otherwise `cc` holds.
- Results leave in issue order. None are dropped or duplicated.
- Reset: `out_valid`=0, S1/S2 valid=0, `result`=0, `zf`=1, `sf`=0, `of`=0, `cc`=3'b100. `in_ready`=1 once reset is released.
- Reset asserted mid-operation discards all in-flight operations immediately. No retire or `cc` update occurs for them.

## Timing
- Latency: an operation accepted at edge N is presented with `out_valid`=1 after edge N+1. It is retirable in cycle N+2 with no stall.
- Throughput: one operation per cycle while `out_ready`=1.
- Handshake rules:
  - S1 advances when S2 is empty or retiring.
  - `in_ready` = !S1.valid || S1 advancing. It is combinational from `out_ready`; no combinational path from `in_valid` to `in_ready`.
  - `out_valid`, `result` and flags are stable while `out_valid && !out_ready`.
- Full condition: with S1 and S2 both valid and `out_ready`=0, `in_ready`=0. The pipeline holds up to 2 operations.
- Simultaneous retire and accept in one cycle: S2 takes S1's operation, S1 takes the new one, and `cc` updates from the retiring S2 entry.
- `cc` changes on the retire edge. It is visible the cycle after retire.
- Issue-side `in_valid` may drop without transfer. Inputs are sampled only on transfer.

## Test plan
- Sub directed: a=−456, b=−154 → result −302, sf=1, zf=0, of=0. a=25620, b=−5264 → 30884. a=58974, b=−254781 → 313755. a=45871, b=154 → 45717. All with flags correct, back-to-back, one result per cycle, 2-cycle latency.
- Equal operands: sub a=b=0xABCDABCDABCDABCD with set_cc=1 → result 0, zf=1. `cc`=3'b100 after retire.
- Overflow: add 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, sf=1, of=1. sub 0x8000_0000_0000_0000 − 1 → of=1. and/xor with the same operands → of=0. Only set_cc=1 ops change `cc`.
- Backpressure: hold out_ready=0, offer 3 ops → 2 accepted, `in_ready`=0, output stable. Release → 3 results in order with no loss or duplication.
- Reset mid-flight: 2 ops in pipeline, rst_n low for one cycle → out_valid=0, cc=3'b100, no retire. Next op completes normally.
- Parametrised: WIDTH=8, add 0x7F+0x01 → 0x80, of=1. sub 0x00−0x01 → 0xFF, sf=1, of=0.
